// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one 2-stage registered add/sub ALU among NUM_REQ requesters,
// with per-issue ID tagging and drain control. Optional per-requester issue counters: ALU_SCHED_STATS_EN.
module alu_sched #(
    parameter int WIDTH   = 6,
    parameter int NUM_REQ = 4,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
`ifdef ALU_SCHED_STATS_EN
    output logic [NUM_REQ*16-1:0]    issue_cnt,
`endif
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [2*NUM_REQ-1:0]     req_op,
    input  logic [WIDTH*NUM_REQ-1:0] req_a,
    input  logic [WIDTH*NUM_REQ-1:0] req_b,
    output logic [1:0]               alu_op,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic                     alu_in_valid,
    input  logic [WIDTH-1:0]         alu_out,
    input  logic                     alu_out_valid,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_data,
    input  logic                     drain_req,
    output logic                     drain_done,
    output logic                     tag_err
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic             alu_in_valid_q, alu_in_valid_d;
    logic [1:0]       alu_op_q, alu_op_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [ID_W-1:0]  issue_id_q, issue_id_d;
    logic             tag_vld_p1_q, tag_vld_p1_d;
    logic [ID_W-1:0]  tag_id_p1_q, tag_id_p1_d;
    logic             tag_vld_p2_q, tag_vld_p2_d;
    logic [ID_W-1:0]  tag_id_p2_q, tag_id_p2_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             tag_err_q, tag_err_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               grant_any;
    logic               in_flight;

    assign in_flight = tag_vld_p1_q | tag_vld_p2_q;

    // Round-robin pick: first valid requester after the pointer, ascending with wrap.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        if (state_q == RUN && !drain_req && !rst) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = (int'(ptr_q) + k) % NUM_REQ;
                if (!grant_any && req_valid[idx]) begin
                    grant_any = 1'b1;
                    grant_id  = ID_W'(idx);
                end
            end
            if (grant_any) begin
                grant[grant_id] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (drain_req) state_d = DRAIN;
            end
            DRAIN: begin
                if (!drain_req) begin
                    state_d = RUN;
                end else if (!in_flight && !alu_in_valid_q) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                if (!drain_req) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        ptr_d          = ptr_q;
        alu_in_valid_d = grant_any;
        alu_op_d       = alu_op_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        issue_id_d     = issue_id_q;
        if (grant_any) begin
            ptr_d      = grant_id;
            alu_op_d   = req_op[int'(grant_id)*2 +: 2];
            alu_a_d    = req_a[int'(grant_id)*WIDTH +: WIDTH];
            alu_b_d    = req_b[int'(grant_id)*WIDTH +: WIDTH];
            issue_id_d = grant_id;
        end

        // Tag pipe mirrors the ALU's two register stages so stage 2 meets alu_out_valid.
        tag_vld_p1_d = alu_in_valid_q;
        tag_id_p1_d  = issue_id_q;
        tag_vld_p2_d = tag_vld_p1_q;
        tag_id_p2_d  = tag_id_p1_q;

        rsp_valid_d = alu_out_valid & tag_vld_p2_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        if (rsp_valid_d) begin
            rsp_id_d   = tag_id_p2_q;
            rsp_data_d = alu_out;
        end

        tag_err_d = tag_err_q | (alu_out_valid & ~tag_vld_p2_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= RUN;
            ptr_q          <= ID_W'(NUM_REQ - 1);
            alu_in_valid_q <= 1'b0;
            alu_op_q       <= '0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            issue_id_q     <= '0;
            tag_vld_p1_q   <= 1'b0;
            tag_id_p1_q    <= '0;
            tag_vld_p2_q   <= 1'b0;
            tag_id_p2_q    <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= '0;
            rsp_data_q     <= '0;
            tag_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            alu_in_valid_q <= alu_in_valid_d;
            alu_op_q       <= alu_op_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            issue_id_q     <= issue_id_d;
            tag_vld_p1_q   <= tag_vld_p1_d;
            tag_id_p1_q    <= tag_id_p1_d;
            tag_vld_p2_q   <= tag_vld_p2_d;
            tag_id_p2_q    <= tag_id_p2_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_id_q       <= rsp_id_d;
            rsp_data_q     <= rsp_data_d;
            tag_err_q      <= tag_err_d;
        end
    end

`ifdef ALU_SCHED_STATS_EN
    logic [15:0] cnt_q [NUM_REQ];
    logic [15:0] cnt_d [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (grant[i] && cnt_q[i] != 16'hFFFF) begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        issue_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) issue_cnt[i*16 +: 16] = cnt_q[i];
    end
`else
    // Statistics disabled: no counter hardware.
`endif

    assign req_ready    = grant;
    assign alu_op       = alu_op_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_in_valid = alu_in_valid_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_data     = rsp_data_q;
    assign drain_done   = (state_q == HALTED);
    assign tag_err      = tag_err_q;

endmodule

// File: tb/tb_alu_sched.sv
// Directed testbench for alu_sched with a 2-stage add/sub ALU model attached.
module tb_alu_sched;

    localparam int WIDTH   = 6;
    localparam int NUM_REQ = 4;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [NUM_REQ-1:0]       req_ready;
    logic [2*NUM_REQ-1:0]     req_op = '0;
    logic [WIDTH*NUM_REQ-1:0] req_a = '0;
    logic [WIDTH*NUM_REQ-1:0] req_b = '0;
    logic [1:0]               alu_op;
    logic [WIDTH-1:0]         alu_a, alu_b;
    logic                     alu_in_valid;
    logic [WIDTH-1:0]         alu_out;
    logic                     alu_out_valid;
    logic                     rsp_valid;
    logic [1:0]               rsp_id;
    logic [WIDTH-1:0]         rsp_data;
    logic                     drain_req = 1'b0;
    logic                     drain_done;
    logic                     tag_err;
    logic                     force_ov = 1'b0;
`ifdef ALU_SCHED_STATS_EN
    logic [NUM_REQ*16-1:0]    issue_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_sched #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .clk(clk),
`ifdef ALU_SCHED_STATS_EN
        .issue_cnt(issue_cnt),
`endif
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op(req_op),
        .req_a(req_a),
        .req_b(req_b),
        .alu_op(alu_op),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_in_valid(alu_in_valid),
        .alu_out(alu_out),
        .alu_out_valid(alu_out_valid),
        .rsp_valid(rsp_valid),
        .rsp_id(rsp_id),
        .rsp_data(rsp_data),
        .drain_req(drain_req),
        .drain_done(drain_done),
        .tag_err(tag_err)
    );

    // Two-stage registered ALU: inputs in cycle n, result valid in cycle n+2.
    logic [WIDTH-1:0] s1_r, s2_r;
    logic             s1_v, s2_v;

    function automatic logic [WIDTH-1:0] alu_fn(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (op)
            2'd1:    return a + b;
            2'd2:    return a - b;
            default: return '0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v <= 1'b0; s1_r <= '0; s2_v <= 1'b0; s2_r <= '0;
        end else begin
            s1_v <= alu_in_valid;
            s1_r <= alu_fn(alu_op, alu_a, alu_b);
            s2_v <= s1_v;
            s2_r <= s1_r;
        end
    end

    assign alu_out       = s2_r;
    assign alu_out_valid = s2_v | force_ov;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        drain_req = 1'b0;
        force_ov = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b);
        req_op[2*i +: 2]     = op;
        req_a[WIDTH*i +: WIDTH] = a;
        req_b[WIDTH*i +: WIDTH] = b;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'hF;
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_ready got %b want 0000", req_ready); end
        n_cmp++; if ({alu_in_valid, alu_op, alu_a, alu_b} !== '0) begin n_bad++; $display("FAIL rst_alu got %b/%0d/%0d/%0d want zeros", alu_in_valid, alu_op, alu_a, alu_b); end
        n_cmp++; if ({rsp_valid, rsp_id, rsp_data} !== '0) begin n_bad++; $display("FAIL rst_rsp got %b/%0d/%0d want zeros", rsp_valid, rsp_id, rsp_data); end
        n_cmp++; if ({drain_done, tag_err} !== 2'b00) begin n_bad++; $display("FAIL rst_flags got %b%b want 00", drain_done, tag_err); end
`ifdef ALU_SCHED_STATS_EN
        n_cmp++; if (issue_cnt !== '0) begin n_bad++; $display("FAIL rst_cnt got %h want 0", issue_cnt); end
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL rst_first_prio got %b want 0001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_single_add();
        do_reset();
        set_req(0, 2'd1, 6'd5, 6'd9);
        req_valid = 4'b0001;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL t1_ready got %b want 0001", req_ready); end
        step();
        req_valid = '0;
        n_cmp++; if ({alu_in_valid, alu_op, alu_a, alu_b} !== {1'b1, 2'd1, 6'd5, 6'd9}) begin n_bad++; $display("FAIL t1_issue got %b/%0d/%0d/%0d want 1/1/5/9", alu_in_valid, alu_op, alu_a, alu_b); end
        step();
        n_cmp++; if ({alu_in_valid, alu_a, alu_b} !== {1'b0, 6'd5, 6'd9}) begin n_bad++; $display("FAIL t1_hold got %b/%0d/%0d want 0/5/9", alu_in_valid, alu_a, alu_b); end
        step();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL t1_early_rsp got %b want 0", rsp_valid); end
        step();
        n_cmp++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, 6'd14}) begin n_bad++; $display("FAIL t1_rsp got %b/%0d/%0d want 1/0/14", rsp_valid, rsp_id, rsp_data); end
        step();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL t1_rsp_clear got %b want 0", rsp_valid); end
    endtask

    task automatic test_round_robin();
        logic [3:0] e_rdy;
        logic [1:0] e_id;
        logic [5:0] e_d;
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 2'd1, 6'(i + 1), 6'(i + 2));
        for (int t = 0; t < 12; t++) begin
            req_valid = (t < 8) ? 4'hF : 4'h0;
            #1;
            if (t < 8) begin
                e_rdy = 4'b0001 << (t % 4);
                n_cmp++; if (req_ready !== e_rdy) begin n_bad++; $display("FAIL t2_grant c%0d got %b want %b", t, req_ready, e_rdy); end
            end
            if (t >= 4) begin
                e_id = 2'((t - 4) % 4);
                e_d  = 6'(2 * ((t - 4) % 4) + 3);
                n_cmp++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, e_id, e_d}) begin n_bad++; $display("FAIL t2_rsp c%0d got %b/%0d/%0d want 1/%0d/%0d", t, rsp_valid, rsp_id, rsp_data, e_id, e_d); end
            end else begin
                n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL t2_norsp c%0d got %b want 0", t, rsp_valid); end
            end
            step();
        end
`ifdef ALU_SCHED_STATS_EN
        n_cmp++; if (issue_cnt !== {16'd2, 16'd2, 16'd2, 16'd2}) begin n_bad++; $display("FAIL t2_cnt got %h want 0002000200020002", issue_cnt); end
`endif
    endtask

    task automatic test_wrap_arith();
        do_reset();
        set_req(2, 2'd2, 6'd3, 6'd5);
        set_req(1, 2'd1, 6'd40, 6'd30);
        req_valid = 4'b0100;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL t3_grant2 got %b want 0100", req_ready); end
        step();
        req_valid = 4'b0010;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL t3_grant1 got %b want 0010", req_ready); end
        step();
        req_valid = '0;
        step();
        step();
        n_cmp++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd2, 6'd62}) begin n_bad++; $display("FAIL t3_sub got %b/%0d/%0d want 1/2/62", rsp_valid, rsp_id, rsp_data); end
        step();
        n_cmp++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd1, 6'd6}) begin n_bad++; $display("FAIL t3_add got %b/%0d/%0d want 1/1/6", rsp_valid, rsp_id, rsp_data); end
        step();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL t3_end got %b want 0", rsp_valid); end
    endtask

    task automatic test_drain();
        logic [3:0] e_rdy;
        logic [1:0] e_id;
        logic [5:0] e_d;
        do_reset();
        for (int i = 0; i < 3; i++) set_req(i, 2'd1, 6'(10 + i), 6'd1);
        req_valid = 4'b0111;
        for (int t = 0; t < 3; t++) begin
            #1;
            e_rdy = 4'b0001 << t;
            n_cmp++; if (req_ready !== e_rdy) begin n_bad++; $display("FAIL t4_grant c%0d got %b want %b", t, req_ready, e_rdy); end
            step();
        end
        drain_req = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL t4_stop got %b want 0000", req_ready); end
        step();
        n_cmp++; if (alu_in_valid !== 1'b0) begin n_bad++; $display("FAIL t4_noissue got %b want 0", alu_in_valid); end
        for (int t = 4; t < 7; t++) begin
            e_id = 2'(t - 4);
            e_d  = 6'(11 + t - 4);
            n_cmp++; if ({rsp_valid, rsp_id, rsp_data, drain_done, req_ready} !== {1'b1, e_id, e_d, 1'b0, 4'b0000}) begin n_bad++; $display("FAIL t4_drain_rsp c%0d got %b/%0d/%0d dd=%b rdy=%b want 1/%0d/%0d dd=0 rdy=0000", t, rsp_valid, rsp_id, rsp_data, drain_done, req_ready, e_id, e_d); end
            step();
        end
        n_cmp++; if ({drain_done, rsp_valid} !== 2'b10) begin n_bad++; $display("FAIL t4_halted got dd=%b rsp=%b want dd=1 rsp=0", drain_done, rsp_valid); end
        step();
        drain_req = 1'b0;
        #1;
        n_cmp++; if ({drain_done, req_ready} !== {1'b1, 4'b0000}) begin n_bad++; $display("FAIL t4_release got dd=%b rdy=%b want dd=1 rdy=0000", drain_done, req_ready); end
        step();
        n_cmp++; if ({drain_done, req_ready} !== {1'b0, 4'b0001}) begin n_bad++; $display("FAIL t4_resume got dd=%b rdy=%b want dd=0 rdy=0001", drain_done, req_ready); end
        req_valid = '0;
        step();
    endtask

    task automatic test_reset_mid_flight();
        do_reset();
        set_req(0, 2'd1, 6'd1, 6'd1);
        set_req(1, 2'd1, 6'd2, 6'd2);
        req_valid = 4'b0011;
        step();
        step();
        rst = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL t5_ready got %b want 0000", req_ready); end
        n_cmp++; if ({alu_in_valid, alu_op, alu_a, alu_b} !== '0) begin n_bad++; $display("FAIL t5_alu got %b/%0d/%0d/%0d want zeros", alu_in_valid, alu_op, alu_a, alu_b); end
        n_cmp++; if ({rsp_valid, rsp_id, rsp_data, drain_done, tag_err} !== '0) begin n_bad++; $display("FAIL t5_rsp got %b/%0d/%0d/%b/%b want zeros", rsp_valid, rsp_id, rsp_data, drain_done, tag_err); end
        step();
        rst = 1'b0;
        req_valid = '0;
        for (int t = 0; t < 6; t++) begin
            step();
            n_cmp++; if ({rsp_valid, tag_err} !== 2'b00) begin n_bad++; $display("FAIL t5_ghost c%0d got rsp=%b err=%b want 0 0", t, rsp_valid, tag_err); end
        end
    endtask

    task automatic test_tag_err();
        do_reset();
        force_ov = 1'b1;
        #1;
        n_cmp++; if (tag_err !== 1'b0) begin n_bad++; $display("FAIL t6_pre got %b want 0", tag_err); end
        step();
        force_ov = 1'b0;
        n_cmp++; if ({tag_err, rsp_valid} !== 2'b10) begin n_bad++; $display("FAIL t6_set got err=%b rsp=%b want 1 0", tag_err, rsp_valid); end
        for (int t = 0; t < 3; t++) begin
            step();
            n_cmp++; if (tag_err !== 1'b1) begin n_bad++; $display("FAIL t6_sticky c%0d got %b want 1", t, tag_err); end
        end
        do_reset();
        n_cmp++; if (tag_err !== 1'b0) begin n_bad++; $display("FAIL t6_clear got %b want 0", tag_err); end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_round_robin();
        test_wrap_arith();
        test_drain();
        test_reset_mid_flight();
        test_tag_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
